// File: rtl/pc_sequencer.sv
// Next-PC controller: picks PC+4 / branch / jump / JR, holds on stall and IMEM wait,
// parks one redirect that arrives during a wait and pulses pipeline flushes per redirect.
module pc_sequencer #(
  parameter int unsigned           WIDTH    = 32,
  parameter logic [WIDTH-1:0]      RESET_PC = '0,
  parameter int unsigned           CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             zero_i,
  input  logic [WIDTH-1:0] branch_target_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jump_target_i,
  input  logic             jr_i,
  input  logic [WIDTH-1:0] jr_target_i,
  input  logic             imem_ready_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             imem_req_o,
  output logic [1:0]       pc_src_o,
  output logic             flush_ifid_o,
  output logic             flush_idex_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  typedef enum logic [1:0] {StBoot, StRun, StWait} state_e;

  localparam logic [WIDTH-1:0] AlignMask = ~WIDTH'(3);
  localparam logic [1:0] SrcInc = 2'b00;
  localparam logic [1:0] SrcBr  = 2'b01;
  localparam logic [1:0] SrcJmp = 2'b10;
  localparam logic [1:0] SrcJr  = 2'b11;

  state_e           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [1:0]       r_pc_src;
  logic             r_req;
  logic             r_flush;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend_vld;
  logic [WIDTH-1:0] r_pend_tgt;
  logic [1:0]       r_pend_src;

  logic             w_rq;
  logic             w_new_redirect;
  logic [WIDTH-1:0] w_tgt;
  logic [1:0]       w_src;
  logic [WIDTH-1:0] w_pc_inc;
  logic             w_cnt_max;

  // Priority JR > jump > taken branch; targets are word-aligned before use.
  always_comb begin
    w_tgt = '0;
    w_src = SrcInc;
    if (jr_i) begin
      w_tgt = jr_target_i & AlignMask;
      w_src = SrcJr;
    end else if (jump_i) begin
      w_tgt = jump_target_i & AlignMask;
      w_src = SrcJmp;
    end else if (branch_i && zero_i) begin
      w_tgt = branch_target_i & AlignMask;
      w_src = SrcBr;
    end
  end

  assign w_rq           = jr_i | jump_i | (branch_i & zero_i);
  // A request behind an already parked redirect belongs to a squashed instruction.
  assign w_new_redirect = w_rq & ~r_pend_vld;
  assign w_pc_inc       = r_pc + WIDTH'(4);
  assign w_cnt_max      = &r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StBoot;
      r_pc       <= RESET_PC & AlignMask;
      r_pc_src   <= SrcInc;
      r_req      <= 1'b0;
      r_flush    <= 1'b0;
      r_cnt      <= '0;
      r_pend_vld <= 1'b0;
      r_pend_tgt <= '0;
      r_pend_src <= SrcInc;
    end else begin
      r_flush <= 1'b0;
      unique case (r_state)
        StBoot: begin
          r_state <= StRun;
          r_req   <= 1'b1;
        end
        StRun, StWait: begin
          if (w_new_redirect) begin
            r_flush <= 1'b1;
            if (!w_cnt_max) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          if (imem_ready_i) begin
            r_state <= StRun;
            if (r_pend_vld) begin
              r_pc       <= r_pend_tgt;
              r_pc_src   <= r_pend_src;
              r_pend_vld <= 1'b0;
            end else if (w_rq) begin
              r_pc     <= w_tgt;
              r_pc_src <= w_src;
            end else if (!stall_i) begin
              r_pc     <= w_pc_inc;
              r_pc_src <= SrcInc;
            end
          end else begin
            r_state <= StWait;
            if (w_new_redirect) begin
              r_pend_vld <= 1'b1;
              r_pend_tgt <= w_tgt;
              r_pend_src <= w_src;
            end
          end
        end
        default: r_state <= StBoot;
      endcase
    end
  end

  assign pc_o           = r_pc;
  assign imem_req_o     = r_req;
  assign pc_src_o       = r_pc_src;
  assign flush_ifid_o   = r_flush;
  assign flush_idex_o   = r_flush;
  assign redirect_cnt_o = r_cnt;

endmodule
